// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin arbiter sharing the AHB-to-APB bridge slave port between
// NUM_M AHB masters. Tracks address-phase (Hmaster) and data-phase (dmaster) ownership across
// wait states and steers the owning masters' signals onto the bridge.
// Optional feature: define ARB_HLOCK_EN to honour Hlock (locked transfers, Hmastlock).
// Reset is synchronous and active-high (Hreset).

module ahb_master_arbiter #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned DEF_M = 0,
  localparam int unsigned MW   = $clog2(NUM_M)
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic [NUM_M-1:0]      Hbusreq,
  input  logic [NUM_M-1:0]      Hlock,
  input  logic                  Hready,
  input  logic [NUM_M*32-1:0]   m_Haddr,
  input  logic [NUM_M*2-1:0]    m_Htrans,
  input  logic [NUM_M-1:0]      m_Hwrite,
  input  logic [NUM_M*32-1:0]   m_Hwdata,
  output logic [NUM_M-1:0]      Hgrant,
  output logic [MW-1:0]         Hmaster,
  output logic                  Hmastlock,
  output logic [31:0]           Haddr,
  output logic [1:0]            Htrans,
  output logic                  Hwrite,
  output logic [31:0]           Hwdata
);

`ifdef ARB_HLOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam logic [MW-1:0]    DefIdx   = MW'(DEF_M);
  localparam logic [NUM_M-1:0] DefGrant = NUM_M'(1) << DEF_M;

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  typedef enum logic [1:0] {
    StPark = 2'b00,
    StOwn  = 2'b01,
    StLock = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]    hmaster_q;
  logic [MW-1:0]    dmaster_q;
  logic [MW-1:0]    last_q, last_d;
  logic             mastlock_q;

  logic [MW-1:0]    gidx;
  logic [1:0]       gtrans;
  logic             glock;
  logic             arb_pt;
  logic             lock_hold;
  logic [MW-1:0]    winner;
  logic             found;
  logic [MW-1:0]    win_hi, win_lo;
  logic             found_hi, found_lo;

  // Encode the one-hot grant and pick up the granted master's transfer type and lock.
  always_comb begin
    gidx   = DefIdx;
    gtrans = TrIdle;
    glock  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (hgrant_q[i]) begin
        gidx = MW'(i);
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (gidx == MW'(i)) begin
        gtrans = m_Htrans[2*i +: 2];
        glock  = Hlock[i];
      end
    end
  end

  // Arbitrate only between transfers: a SEQ or BUSY from the granted master means a burst is
  // still running. A master that dropped Hbusreq is likewise only released on IDLE/NONSEQ,
  // so the same condition covers both cases.
  always_comb begin
    arb_pt    = Hready && (gtrans == TrIdle || gtrans == TrNonseq) && (gtrans != TrSeq) &&
                (gtrans != TrBusy);
    lock_hold = LockEn && (state_q == StLock) && glock;
  end

  // Round-robin search: first requester above last, else lowest requester at or below last,
  // which places the current owner at the end of the scan.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = last_q;
    win_lo   = last_q;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (Hbusreq[i] && (MW'(i) > last_q)) begin
        found_hi = 1'b1;
        win_hi   = MW'(i);
      end
      if (Hbusreq[i] && (MW'(i) <= last_q)) begin
        found_lo = 1'b1;
        win_lo   = MW'(i);
      end
    end
    found  = found_hi || found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  // Next grant, round-robin pointer and FSM state.
  always_comb begin
    hgrant_d = hgrant_q;
    last_d   = last_q;
    state_d  = state_q;
    if (arb_pt && !lock_hold) begin
      if (found) begin
        hgrant_d         = '0;
        hgrant_d[winner] = 1'b1;
        last_d           = winner;
        state_d          = (LockEn && Hlock[winner]) ? StLock : StOwn;
      end else begin
        hgrant_d = DefGrant;
        state_d  = StPark;
      end
    end
  end

  // Grant, ownership pipeline and lock flag; all frozen while the bridge stalls.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      hgrant_q   <= DefGrant;
      hmaster_q  <= DefIdx;
      dmaster_q  <= DefIdx;
      last_q     <= DefIdx;
      state_q    <= StPark;
      mastlock_q <= 1'b0;
    end else if (Hready) begin
      hgrant_q   <= hgrant_d;
      last_q     <= last_d;
      state_q    <= state_d;
      hmaster_q  <= gidx;
      dmaster_q  <= hmaster_q;
      // The address phase starting now belongs to a master granted in LOCK.
      mastlock_q <= LockEn && (state_q == StLock);
    end
  end

  // Steer address/control from the address-phase owner and write data from the data-phase owner.
  always_comb begin
    Haddr  = '0;
    Htrans = TrIdle;
    Hwrite = 1'b0;
    Hwdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (hmaster_q == MW'(i)) begin
        Haddr  = m_Haddr[32*i +: 32];
        Htrans = m_Htrans[2*i +: 2];
        Hwrite = m_Hwrite[i];
      end
      if (dmaster_q == MW'(i)) begin
        Hwdata = m_Hwdata[32*i +: 32];
      end
    end
  end

  assign Hgrant    = hgrant_q;
  assign Hmaster   = hmaster_q;
  assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter (NUM_M = 4, DEF_M = 0).
// Directed scenarios plus a randomized run against a behavioural model of the arbitration rules.

module tb_ahb_master_arbiter;

  localparam int unsigned NUM_M = 4;
  localparam int unsigned DEF_M = 0;
  localparam int unsigned MW    = $clog2(NUM_M);

`ifdef ARB_HLOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic                Hclk = 1'b0;
  logic                Hreset;
  logic [NUM_M-1:0]    Hbusreq;
  logic [NUM_M-1:0]    Hlock;
  logic                Hready;
  logic [NUM_M*32-1:0] m_Haddr;
  logic [NUM_M*2-1:0]  m_Htrans;
  logic [NUM_M-1:0]    m_Hwrite;
  logic [NUM_M*32-1:0] m_Hwdata;
  logic [NUM_M-1:0]    Hgrant;
  logic [MW-1:0]       Hmaster;
  logic                Hmastlock;
  logic [31:0]         Haddr;
  logic [1:0]          Htrans;
  logic                Hwrite;
  logic [31:0]         Hwdata;

  logic [31:0] addr  [NUM_M];
  logic [1:0]  trans [NUM_M];
  logic        wr    [NUM_M];
  logic [31:0] wdata [NUM_M];

  int total = 0;
  int bad   = 0;

  // Reference model: indices of granted, address-phase and data-phase masters, rr pointer.
  int mg, mh, md, ml;
  bit mlocked;   // current grant was made to a locking master
  bit mmlock;    // expected Hmastlock

  always #5 Hclk = ~Hclk;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      m_Haddr[32*i +: 32] = addr[i];
      m_Htrans[2*i +: 2]  = trans[i];
      m_Hwrite[i]         = wr[i];
      m_Hwdata[32*i +: 32] = wdata[i];
    end
  end

  ahb_master_arbiter #(
    .NUM_M (NUM_M),
    .DEF_M (DEF_M)
  ) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Hready    (Hready),
    .m_Haddr   (m_Haddr),
    .m_Htrans  (m_Htrans),
    .m_Hwrite  (m_Hwrite),
    .m_Hwdata  (m_Hwdata),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmastlock (Hmastlock),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hwdata    (Hwdata)
  );

  // One clock edge: advance the model from the inputs the DUT samples, then settle.
  task automatic tick();
    int gt;
    int w;
    int c;
    @(posedge Hclk);
    if (Hreset) begin
      mg = DEF_M; mh = DEF_M; md = DEF_M; ml = DEF_M;
      mlocked = 1'b0; mmlock = 1'b0;
    end else if (Hready) begin
      gt = int'(trans[mg]);
      md = mh;
      mh = mg;
      mmlock = mlocked;
      // IDLE (0) or NONSEQ (2) from the granted master ends its claim on the bus.
      if ((gt == 0 || gt == 2) && !(LockEn && mlocked && Hlock[mg])) begin
        w = -1;
        for (int k = 1; k <= NUM_M; k++) begin
          c = (ml + k) % NUM_M;
          if (w < 0 && Hbusreq[c]) w = c;
        end
        if (w >= 0) begin
          mg = w; ml = w; mlocked = LockEn && Hlock[w];
        end else begin
          mg = DEF_M; mlocked = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    Hbusreq = '0;
    Hlock   = '0;
    Hready  = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      addr[i]  = $urandom;
      trans[i] = 2'b00;
      wr[i]    = 1'b0;
      wdata[i] = $urandom;
    end
  endtask

  task automatic rand_inputs();
    Hbusreq = NUM_M'($urandom);
    Hlock   = NUM_M'($urandom);
    Hready  = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NUM_M; i++) begin
      addr[i]  = $urandom;
      trans[i] = 2'($urandom);
      wr[i]    = 1'($urandom);
      wdata[i] = $urandom;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0;
  endtask

  task automatic test_reset();
    rand_inputs();
    Hreset = 1'b1;
    tick();
    tick();
    total++;
    if (Hgrant !== 4'b0001) begin
      bad++; $display("FAIL reset_grant: got %b want %b", Hgrant, 4'b0001);
    end
    total++;
    if (Hmaster !== 2'd0) begin
      bad++; $display("FAIL reset_hmaster: got %0d want 0", Hmaster);
    end
    total++;
    if (Hmastlock !== 1'b0) begin
      bad++; $display("FAIL reset_mastlock: got %b want 0", Hmastlock);
    end
    total++;
    if (Haddr !== addr[0] || Hwdata !== wdata[0]) begin
      bad++; $display("FAIL reset_mux: got %h/%h want %h/%h", Haddr, Hwdata, addr[0], wdata[0]);
    end
    Hreset = 1'b0;
    idle_inputs();
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (Hgrant !== 4'b0001 || Hmaster !== 2'd0) begin
      bad++; $display("FAIL reset_park: got grant %b master %0d want 0001/0", Hgrant, Hmaster);
    end
  endtask

  task automatic test_single();
    do_reset();
    Hbusreq = 4'b0100;
    tick();
    total++;
    if (Hgrant !== 4'b0100 || Hmaster !== 2'd0) begin
      bad++; $display("FAIL single_grant: got %b/%0d want 0100/0", Hgrant, Hmaster);
    end
    trans[2] = 2'b10;
    tick();
    total++;
    if (Hmaster !== 2'd2 || Haddr !== addr[2] || Htrans !== 2'b10) begin
      bad++; $display("FAIL single_owner: got %0d %h %b want 2 %h 10", Hmaster, Haddr, Htrans,
                      addr[2]);
    end
    Hbusreq  = '0;
    trans[2] = 2'b00;
    tick();
    total++;
    if (Hgrant !== 4'b0001) begin
      bad++; $display("FAIL single_park: got %b want 0001", Hgrant);
    end
  endtask

  task automatic test_round_robin();
    int          exp_g [5] = '{1, 2, 3, 0, 1};
    int          exp_m [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  eg;
    do_reset();
    Hbusreq = 4'b1111;
    for (int i = 0; i < NUM_M; i++) trans[i] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      eg = 4'b0001 << exp_g[k];
      total++;
      if (Hgrant !== eg || Hmaster !== 2'(exp_m[k])) begin
        bad++; $display("FAIL rr_step%0d: got %b/%0d want %b/%0d", k, Hgrant, Hmaster, eg,
                        exp_m[k]);
      end
    end
  endtask

  task automatic test_burst_wait();
    do_reset();
    wdata[1] = 32'h1111_0001;
    wdata[3] = 32'h3333_0003;
    Hbusreq  = 4'b0010;
    tick();
    total++;
    if (Hgrant !== 4'b0010) begin
      bad++; $display("FAIL burst_grant: got %b want 0010", Hgrant);
    end
    tick();
    trans[1] = 2'b10;
    tick();
    trans[1] = 2'b11;
    Hbusreq  = 4'b1010;
    tick();
    Hready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (Hgrant !== 4'b0010 || Hmaster !== 2'd1 || Hwdata !== wdata[1]) begin
        bad++; $display("FAIL burst_stall%0d: got %b/%0d/%h want 0010/1/%h", k, Hgrant, Hmaster,
                        Hwdata, wdata[1]);
      end
    end
    Hready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (Hgrant !== 4'b0010) begin
        bad++; $display("FAIL burst_hold%0d: got %b want 0010", k, Hgrant);
      end
    end
    trans[1] = 2'b00;
    Hbusreq  = 4'b1000;
    tick();
    total++;
    if (Hgrant !== 4'b1000 || Hmaster !== 2'd1) begin
      bad++; $display("FAIL burst_handover: got %b/%0d want 1000/1", Hgrant, Hmaster);
    end
    tick();
    total++;
    if (Hmaster !== 2'd3) begin
      bad++; $display("FAIL burst_newowner: got %0d want 3", Hmaster);
    end
  endtask

  task automatic test_data_steer();
    do_reset();
    wr[0] = 1'b1; wr[2] = 1'b1;
    wdata[0] = $urandom;
    wdata[2] = ~wdata[0];
    Hbusreq  = 4'b0101;
    trans[0] = 2'b10;
    tick();
    total++;
    if (Hgrant !== 4'b0100) begin
      bad++; $display("FAIL steer_grant: got %b want 0100", Hgrant);
    end
    Hbusreq  = 4'b0100;
    trans[0] = 2'b00;
    trans[2] = 2'b10;
    tick();
    total++;
    if (Hmaster !== 2'd2 || Hwdata !== wdata[0] || Haddr !== addr[2] || Hwrite !== 1'b1) begin
      bad++; $display("FAIL steer_overlap: got %0d %h %h want 2 %h %h", Hmaster, Hwdata, Haddr,
                      wdata[0], addr[2]);
    end
    Hbusreq  = '0;
    trans[2] = 2'b00;
    tick();
    total++;
    if (Hwdata !== wdata[2]) begin
      bad++; $display("FAIL steer_data2: got %h want %h", Hwdata, wdata[2]);
    end
  endtask

`ifdef ARB_HLOCK_EN
  task automatic test_lock();
    do_reset();
    Hbusreq = 4'b1001;
    Hlock   = 4'b1000;
    tick();
    tick();
    trans[3] = 2'b10;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (Hgrant !== 4'b1000 || Hmaster !== 2'd3 || Hmastlock !== 1'b1) begin
        bad++; $display("FAIL lock_xfer%0d: got %b/%0d/%b want 1000/3/1", k, Hgrant, Hmaster,
                        Hmastlock);
      end
      tick();
    end
    Hlock    = '0;
    Hbusreq  = 4'b0001;
    trans[3] = 2'b00;
    tick();
    total++;
    if (Hgrant !== 4'b0001) begin
      bad++; $display("FAIL lock_release: got %b want 0001", Hgrant);
    end
    tick();
    total++;
    if (Hmaster !== 2'd0 || Hmastlock !== 1'b0) begin
      bad++; $display("FAIL lock_after: got %0d/%b want 0/0", Hmaster, Hmastlock);
    end
  endtask
`endif

  task automatic test_random();
    logic [NUM_M-1:0] eg;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      Hreset = ($urandom_range(0, 49) == 0);
      tick();
      eg = '0;
      eg[mg] = 1'b1;
      total++;
      if (Hgrant !== eg) begin
        bad++; $display("FAIL rand_grant@%0d: got %b want %b", n, Hgrant, eg);
      end
      total++;
      if (Hmaster !== MW'(mh)) begin
        bad++; $display("FAIL rand_hmaster@%0d: got %0d want %0d", n, Hmaster, mh);
      end
      total++;
      if (Hmastlock !== mmlock) begin
        bad++; $display("FAIL rand_mastlock@%0d: got %b want %b", n, Hmastlock, mmlock);
      end
      total++;
      if (Haddr !== addr[mh] || Htrans !== trans[mh] || Hwrite !== wr[mh]) begin
        bad++; $display("FAIL rand_addr@%0d: got %h/%b/%b want %h/%b/%b", n, Haddr, Htrans,
                        Hwrite, addr[mh], trans[mh], wr[mh]);
      end
      total++;
      if (Hwdata !== wdata[md]) begin
        bad++; $display("FAIL rand_wdata@%0d: got %h want %h", n, Hwdata, wdata[md]);
      end
    end
    Hreset = 1'b0;
  endtask

  initial begin
    Hreset = 1'b1;
    idle_inputs();
    mg = DEF_M; mh = DEF_M; md = DEF_M; ml = DEF_M;
    mlocked = 1'b0; mmlock = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_wait();
    test_data_steer();
`ifdef ARB_HLOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
